// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: holds the architectural PC, issues one instruction-memory read
// at a time and buffers returned words with their PCs for decode.
// Optional build macro: FETCH_PERF_CNT_EN enables the fetched/dropped counters;
// without it perf_fetched/perf_dropped are tied to zero.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  output logic [31:0] pc_plus4,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(BUF_DEPTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDrop = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [PtrW:0]   count_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [31:0]     buf_data_q [BUF_DEPTH];
  logic [31:0]     buf_pc_q   [BUF_DEPTH];

  logic req_fire, pop, push, resp_drop;

  assign pc_plus4      = pc_q + 32'd4;
  assign imem_req_addr = pc_q;
  // Gated by rst_n so the request valid drops the moment reset asserts.
  assign imem_req_valid = rst_n && (state_q == StIdle) && (count_q < DepthCnt);
  assign inst_valid     = (count_q != '0);
  assign inst_data      = buf_data_q[rd_ptr_q];
  assign inst_pc        = buf_pc_q[rd_ptr_q];

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign pop       = inst_valid && inst_ready;
  // Only a response to a live request that is not being flushed reaches the buffer.
  assign push      = (state_q == StWait) && imem_resp_valid && !redirect;
  assign resp_drop = imem_resp_valid &&
                     ((state_q == StDrop) || ((state_q == StWait) && redirect));

  // Next state and next PC; redirect overrides sequential advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      StIdle: if (req_fire) state_d = redirect ? StDrop : StWait;
      StWait: begin
        if (imem_resp_valid) state_d = StIdle;
        else if (redirect)   state_d = StDrop;
      end
      StDrop: if (imem_resp_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (redirect)  pc_d = {next_pc[31:2], 2'b00};
    else if (push) pc_d = pc_plus4;
  end

  // FSM state and architectural PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (redirect) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Buffer storage; cleared on reset so inst_data/inst_pc read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else if (push) begin
      buf_data_q[wr_ptr_q] <= imem_resp_data;
      buf_pc_q[wr_ptr_q]   <= pc_q;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, dropped_q;

  // Performance counters, free-running and wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      dropped_q <= '0;
    end else begin
      if (push)      fetched_q <= fetched_q + 32'd1;
      if (resp_drop) dropped_q <= dropped_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_dropped = dropped_q;
`else
  logic unused_drop;
  assign unused_drop  = resp_drop;
  assign perf_fetched = '0;
  assign perf_dropped = '0;
`endif

endmodule
